shift_reg_univ: RTL

- Parametrised universal register: WIDTH-bit, edge-triggered bank with enable and 8 operating modes (hold, parallel load, logical shifts, rotates, arithmetic shift right, clear).
- Keeps the true/complement output pair (o_q / o_qn) of the storage-element family.
- Adds serial I/O, a shift-out flag and a zero flag.
- Used as the general storage/shift element for datapath and serial-conversion labs.

---
 rtl/shift_reg_pkg.sv | 17 +
 rtl/d_ff_en.sv | 21 ++
 rtl/shift_reg_univ.sv | 86 ++++++++
 3 files changed

// File: rtl/shift_reg_pkg.sv
// Shared types for the universal shift register.
// MODE_W : width of the operation select
// mode_e : operation encodings 0..7 (hold, load, shifts, rotates, asr, clear)
package shift_reg_pkg;
  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_HOLD = 3'd0,
    MODE_LOAD = 3'd1,
    MODE_SHL  = 3'd2,
    MODE_SHR  = 3'd3,
    MODE_ROL  = 3'd4,
    MODE_ROR  = 3'd5,
    MODE_ASR  = 3'd6,
    MODE_CLR  = 3'd7
  } mode_e;
endpackage

// File: rtl/d_ff_en.sv
// 1-bit rising-edge flip-flop with clock enable and true/complement outputs.
// i_clk : clock            i_rst : async active-high reset (loads RST_VAL)
// i_en  : enable (0=hold)  i_d   : data in
// o_q   : stored bit       o_qn  : ~o_q
module d_ff_en #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_d,
  output logic o_q,
  output logic o_qn
);
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)     o_q <= RST_VAL;
    else if (i_en) o_q <= i_d;
  end

  assign o_qn = ~o_q;
endmodule

// File: rtl/shift_reg_univ.sv
// Universal WIDTH-bit register: hold/load/shl/shr/rol/ror/asr/clr.
// i_clk, i_rst (async active-high), i_en (0 = hold everything),
// i_mode (mode_e), i_d (parallel data), i_sin (serial in for SHL/SHR)
// o_q / o_qn (contents and complement), o_sout (last bit shifted out,
// registered), o_zero (combinational o_q == 0)
module shift_reg_univ
  import shift_reg_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic [MODE_W-1:0] i_mode,
  input  logic [WIDTH-1:0]  i_d,
  input  logic              i_sin,
  output logic [WIDTH-1:0]  o_q,
  output logic [WIDTH-1:0]  o_qn,
  output logic              o_sout,
  output logic              o_zero
);
  mode_e            mode;
  logic [WIDTH-1:0] q_nxt;
  logic             sout_nxt;

  assign mode = mode_e'(i_mode);

  // Next-state mux; enable gating lives in the cells so i_en=0 holds
  // both the bank and the sout bit regardless of mode.
  always_comb begin
    q_nxt    = o_q;
    sout_nxt = o_sout;
    unique case (mode)
      MODE_HOLD: ;
      MODE_LOAD: q_nxt = i_d;
      MODE_SHL: begin
        q_nxt    = {o_q[WIDTH-2:0], i_sin};
        sout_nxt = o_q[WIDTH-1];
      end
      MODE_SHR: begin
        q_nxt    = {i_sin, o_q[WIDTH-1:1]};
        sout_nxt = o_q[0];
      end
      MODE_ROL: begin
        q_nxt    = {o_q[WIDTH-2:0], o_q[WIDTH-1]};
        sout_nxt = o_q[WIDTH-1];
      end
      MODE_ROR: begin
        q_nxt    = {o_q[0], o_q[WIDTH-1:1]};
        sout_nxt = o_q[0];
      end
      MODE_ASR: begin
        q_nxt    = {o_q[WIDTH-1], o_q[WIDTH-1:1]};
        sout_nxt = o_q[0];
      end
      MODE_CLR: begin
        q_nxt    = '0;
        sout_nxt = 1'b0;
      end
      default: ;
    endcase
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    d_ff_en #(.RST_VAL(RESET_VALUE[i])) u_ff (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_en  (i_en),
      .i_d   (q_nxt[i]),
      .o_q   (o_q[i]),
      .o_qn  (o_qn[i])
    );
  end

  d_ff_en #(.RST_VAL(1'b0)) u_sout (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_en  (i_en),
    .i_d   (sout_nxt),
    .o_q   (o_sout),
    .o_qn  ()
  );

  assign o_zero = ~|o_q;
endmodule
